// File: rtl/pe_result_packer.sv
// pe_result_packer: packs 32-bit PE results into 512-bit lines, buffers up to two
// lines in a skid FIFO and writes them to the output SRAM over a valid/ready port.
// Optional build macro PE_PACK_RELU_EN clamps negative (signed) results to zero.
module pe_result_packer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINE_W = 512,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_num,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_vld,
  output logic [LINE_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_vld,
  input  logic              wr_rdy,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  localparam int unsigned LANES  = LINE_W / DATA_W;
  localparam int unsigned LANE_W = $clog2(LANES);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   line_idx_q, line_idx_d;
  logic [LINE_W-1:0]   fill_q, fill_d;
  logic                ovf_q, ovf_d;
  logic [1:0]          occ_q, occ_d;
  logic [LINE_W-1:0]   slot0_data_q, slot0_data_d, slot1_data_q, slot1_data_d;
  logic [ADDR_W-1:0]   slot0_addr_q, slot0_addr_d, slot1_addr_q, slot1_addr_d;
  logic                wr_vld_q, wr_vld_d;
  logic [LINE_W-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;

  logic [DATA_W-1:0]   lane_val;
  logic [LINE_W-1:0]   line_new;
  logic [ADDR_W-1:0]   commit_addr;
  logic                accept, last_res, commit, pop, drop, push;
  logic [1:0]          push_idx;

  // Lane value, line assembly and push/pop/drop decisions for this cycle
  always_comb begin
`ifdef PE_PACK_RELU_EN
    lane_val = res_data[DATA_W-1] ? '0 : res_data;
`else
    lane_val = res_data;
`endif
    line_new = fill_q;
    line_new[int'(lane_q)*DATA_W +: DATA_W] = lane_val;
    accept      = (state_q == StRun) && res_vld;
    last_res    = (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) == num_q;
    commit      = accept && ((lane_q == LANE_W'(LANES - 1)) || last_res);
    commit_addr = base_q + line_idx_q;
    pop         = wr_vld_q && wr_rdy;
    // Line is dropped only when both slots stay occupied across this edge
    drop        = commit && (occ_q == 2'd2) && !pop;
    push        = commit && !drop;
    push_idx    = pop ? occ_q - 2'd1 : occ_q;
  end

  // Job FSM, fill register and counters
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    base_d     = base_q;
    line_idx_d = line_idx_q;
    fill_d     = fill_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          base_d     = cfg_base_addr;
          num_d      = cfg_num;
          cnt_d      = '0;
          lane_d     = '0;
          line_idx_d = '0;
          fill_d     = '0;
          ovf_d      = 1'b0;
          state_d    = (cfg_num == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (accept) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (commit) begin
            lane_d     = '0;
            fill_d     = '0;
            line_idx_d = line_idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end else begin
            lane_d = lane_q + {{(LANE_W-1){1'b0}}, 1'b1};
            fill_d = line_new;
          end
          if (drop) ovf_d = 1'b1;
          if (last_res) state_d = StDrain;
        end
      end
      StDrain: begin
        if (occ_q == 2'd0) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Two-slot shift FIFO; slot0 is the head
  always_comb begin
    occ_d        = occ_q;
    slot0_data_d = slot0_data_q;
    slot0_addr_d = slot0_addr_q;
    slot1_data_d = slot1_data_q;
    slot1_addr_d = slot1_addr_q;
    if (pop) begin
      slot0_data_d = slot1_data_q;
      slot0_addr_d = slot1_addr_q;
      occ_d        = occ_q - 2'd1;
    end
    if (push) begin
      if (push_idx == 2'd0) begin
        slot0_data_d = line_new;
        slot0_addr_d = commit_addr;
      end else begin
        slot1_data_d = line_new;
        slot1_addr_d = commit_addr;
      end
      occ_d = push_idx + 2'd1;
    end
  end

  // Write port registered from the head as it stands after this edge's pop;
  // a line pushed this edge shows up one cycle later
  always_comb begin
    if (pop) begin
      wr_vld_d  = (occ_q == 2'd2);
      wr_data_d = slot1_data_q;
      wr_addr_d = slot1_addr_q;
    end else begin
      wr_vld_d  = (occ_q != 2'd0);
      wr_data_d = slot0_data_q;
      wr_addr_d = slot0_addr_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      lane_q       <= '0;
      cnt_q        <= '0;
      num_q        <= '0;
      base_q       <= '0;
      line_idx_q   <= '0;
      fill_q       <= '0;
      ovf_q        <= 1'b0;
      occ_q        <= 2'd0;
      slot0_data_q <= '0;
      slot0_addr_q <= '0;
      slot1_data_q <= '0;
      slot1_addr_q <= '0;
      wr_vld_q     <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      cnt_q        <= cnt_d;
      num_q        <= num_d;
      base_q       <= base_d;
      line_idx_q   <= line_idx_d;
      fill_q       <= fill_d;
      ovf_q        <= ovf_d;
      occ_q        <= occ_d;
      slot0_data_q <= slot0_data_d;
      slot0_addr_q <= slot0_addr_d;
      slot1_data_q <= slot1_data_d;
      slot1_addr_q <= slot1_addr_d;
      wr_vld_q     <= wr_vld_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
    end
  end

  assign wr_vld  = wr_vld_q;
  assign wr_data = wr_data_q;
  assign wr_addr = wr_addr_q;
  assign busy    = (state_q == StRun) || (state_q == StDrain);
  assign done    = (state_q == StDone);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_pe_result_packer.sv
// Self-checking bench for pe_result_packer: a reference line model fills a scoreboard
// queue, and a monitor pops and compares every SRAM write. Honours PE_PACK_RELU_EN.
module tb_pe_result_packer;

  localparam int AW = 10;
  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [AW-1:0] cfg_base_addr;
  logic [15:0]   cfg_num;
  logic [31:0]   res_data;
  logic          res_vld;
  logic [LW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic          wr_vld;
  logic          wr_rdy;
  logic          busy;
  logic          done;
  logic          ovf;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  logic          stall = 1'b0;
  logic [AW-1:0] h_addr;
  logic [LW-1:0] h_data;

  pe_result_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cfg_base_addr(cfg_base_addr),
    .cfg_num      (cfg_num),
    .res_data     (res_data),
    .res_vld      (res_vld),
    .wr_data      (wr_data),
    .wr_addr      (wr_addr),
    .wr_vld       (wr_vld),
    .wr_rdy       (wr_rdy),
    .busy         (busy),
    .done         (done),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef PE_PACK_RELU_EN
    return v[31] ? 32'h0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: results v0+i, lines pushed at base+index, only the first max_push kept
  task automatic expect_job(input logic [AW-1:0] base, input int num, input logic [31:0] v0,
                            input int max_push);
    logic [LW-1:0] line;
    int            idx;
    line = '0;
    idx  = 0;
    for (int i = 0; i < num; i++) begin
      line[(i % 16) * 32 +: 32] = relu(v0 + 32'(i));
      if ((i % 16 == 15) || (i == num - 1)) begin
        if (idx < max_push) exp_q.push_back({base + AW'(idx), line});
        line = '0;
        idx++;
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [AW-1:0] base, input int num);
    cfg_base_addr = base;
    cfg_num       = 16'(num);
    cfg_start     = 1'b1;
    tick;
    cfg_start = 1'b0;
  endtask

  task automatic drive(input int first, input int n, input logic [31:0] v0);
    for (int i = first; i < first + n; i++) begin
      res_data = v0 + 32'(i);
      res_vld  = 1'b1;
      tick;
    end
    res_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick;
      n++;
    end
    check(tag, LW'(done), LW'(1));
    tick;
    check({tag, "_pulse_end"}, LW'(done), LW'(0));
    check({tag, "_idle"}, LW'(busy), LW'(0));
  endtask

  // Write monitor: scoreboard compare on each transfer, stability check while stalled
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (stall) begin
        check("hold_vld", LW'(wr_vld), LW'(1));
        check("hold_addr", LW'(wr_addr), LW'(h_addr));
        check("hold_data", wr_data, h_data);
      end
      if (wr_vld && wr_rdy) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write: observed addr %0h expected no write", wr_addr);
        end
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", LW'(wr_addr), LW'(e.addr));
          check("wr_data", wr_data, e.data);
        end
      end
      stall  = wr_vld && !wr_rdy;
      h_addr = wr_addr;
      h_data = wr_data;
    end else begin
      stall = 1'b0;
    end
  end

  initial begin
    rst_n         = 1'b0;
    cfg_start     = 1'b0;
    cfg_base_addr = '0;
    cfg_num       = '0;
    res_data      = '0;
    res_vld       = 1'b0;
    wr_rdy        = 1'b1;
    tick;
    tick;
    check("rst_wr_vld", LW'(wr_vld), LW'(0));
    check("rst_wr_data", wr_data, '0);
    check("rst_wr_addr", LW'(wr_addr), LW'(0));
    check("rst_busy", LW'(busy), LW'(0));
    check("rst_done", LW'(done), LW'(0));
    check("rst_ovf", LW'(ovf), LW'(0));
    rst_n = 1'b1;
    tick;

    // Full line with latency check
    expect_job(10'h010, 16, 32'd1, 16);
    start(10'h010, 16);
    check("busy_run", LW'(busy), LW'(1));
    drive(0, 16, 32'd1);
    check("lat_not_yet", LW'(wr_vld), LW'(0));
    tick;
    check("lat_vld", LW'(wr_vld), LW'(1));
    check("full_addr", LW'(wr_addr), LW'(10'h010));
    check("full_lane0", LW'(wr_data[31:0]), LW'(32'd1));
    check("full_lane15", LW'(wr_data[511:480]), LW'(32'd16));
    wait_done("full_done", 20);

    // Partial last line
    expect_job(10'h010, 20, 32'h100, 16);
    start(10'h010, 20);
    drive(0, 20, 32'h100);
    wait_done("partial_done", 20);

    // Backpressure and overflow: third line dropped
    wr_rdy = 1'b0;
    expect_job(10'h080, 48, 32'h200, 2);
    start(10'h080, 48);
    drive(0, 48, 32'h200);
    tick;
    tick;
    check("ovf_set", LW'(ovf), LW'(1));
    check("ovf_held_vld", LW'(wr_vld), LW'(1));
    check("ovf_held_addr", LW'(wr_addr), LW'(10'h080));
    check("ovf_busy", LW'(busy), LW'(1));
    wr_rdy = 1'b1;
    wait_done("ovf_done", 20);
    check("ovf_sticky", LW'(ovf), LW'(1));

    // Zero-length job: done one cycle after cfg_start, ovf cleared
    start(10'h033, 0);
    check("zero_done", LW'(done), LW'(1));
    check("ovf_cleared", LW'(ovf), LW'(0));
    tick;
    check("zero_done_end", LW'(done), LW'(0));
    check("zero_no_write", LW'(wr_vld), LW'(0));

    // cfg_start during RUN is ignored
    expect_job(10'h020, 16, 32'h500, 16);
    start(10'h020, 16);
    drive(0, 8, 32'h500);
    start(10'h055, 3);
    check("restart_busy", LW'(busy), LW'(1));
    drive(8, 8, 32'h500);
    wait_done("restart_done", 20);

    // Address wrap
    expect_job(10'h3FF, 32, 32'h700, 16);
    start(10'h3FF, 32);
    drive(0, 32, 32'h700);
    wait_done("wrap_done", 20);

    // Reset mid-job discards everything
    start(10'h040, 16);
    drive(0, 8, 32'h900);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", LW'(wr_vld), LW'(0));
    check("mid_rst_data", wr_data, '0);
    check("mid_rst_addr", LW'(wr_addr), LW'(0));
    check("mid_rst_busy", LW'(busy), LW'(0));
    check("mid_rst_done", LW'(done), LW'(0));
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("post_rst_done", LW'(done), LW'(0));
      check("post_rst_busy", LW'(busy), LW'(0));
    end

    // Negative result in lane 0
    expect_job(10'h100, 1, 32'hFFFF_FFF0, 16);
    start(10'h100, 1);
    drive(0, 1, 32'hFFFF_FFF0);
    tick;
    check("neg_vld", LW'(wr_vld), LW'(1));
`ifdef PE_PACK_RELU_EN
    check("neg_lane0", LW'(wr_data[31:0]), LW'(32'h0));
`else
    check("neg_lane0", LW'(wr_data[31:0]), LW'(32'hFFFF_FFF0));
`endif
    wait_done("neg_done", 20);

    tick;
    check("scoreboard_empty", LW'(exp_q.size()), LW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
